bus_subordinate_mem: RTL and testbench
======================================

Name: bus_subordinate_mem

Overview:
- Memory-mapped subordinate that sits directly downstream of the bus manager on the shared bus_if. It is the block that answers manager write and read transactions.
- Contents: a DEPTH x 32-bit word memory, a programmable wait-state counter, address range checking, and a one-cycle ready pulse.
- A handshake FSM guarantees each manager request is serviced exactly once, even while the manager holds valid after ready.

Parameters:
- BASE_ADDR, 8'h00, first word address decoded by this subordinate.
- DEPTH, 128, number of 32-bit words. Range 1..256; BASE_ADDR+DEPTH must be <= 256.
- WAIT_CYCLES, 2, wait states inserted between request capture and the ready pulse. Range 0..15.
- ERR_RDATA, 32'hDEAD_BEEF, read data returned for out-of-range reads.

Ports:
- clk  in  1  bus clock (bus_if clk); all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- valid  in  1  manager request valid; held high until the manager sees ready.
- wr_en  in  1  1 = write, 0 = read; qualified by valid.
- addr  in  8  word address.
- wdata  in  32  write data.
- ready  out  1  transaction-complete pulse, exactly one cycle per transaction.
- rdata  out  32  read data; valid while ready=1 and held until the next read completes.
- err  out  1  out-of-range flag; asserted together with ready for exactly that cycle.

Behaviour:
- Reset (async assert, sync deassert by design): state=IDLE, ready=0, err=0, rdata=0, wait counter=0, captured request=0, all memory words=0.
- Address decode: in_range = (addr >= BASE_ADDR) && (addr - BASE_ADDR < DEPTH). Index = addr - BASE_ADDR, in 8-bit arithmetic with no wrap past 255.
- FSM states are IDLE, WAIT, ACCESS, DONE.
- IDLE: on a clk edge with valid=1, capture addr, wr_en, wdata and in_range.
  - If WAIT_CYCLES>0: load counter with WAIT_CYCLES-1 and go to WAIT.
  - If WAIT_CYCLES=0: go to ACCESS.
- WAIT: decrement the counter each cycle. When counter==0, go to ACCESS. Inputs are not resampled; the captured values are used.
- ACCESS (one cycle): register ready=1.
  - Write, in range: mem[index] <= captured wdata.
  - Write, out of range: drop the write and set err=1.
  - Read, in range: rdata <= mem[index].
  - Read, out of range: rdata <= ERR_RDATA and set err=1.
  - Next state is DONE.
- DONE: ready=0 and err=0.
  - Stay in DONE while valid=1, so a held valid is never re-accepted.
  - Return to IDLE on the first edge that samples valid=0.
- Latency: valid sampled at edge N gives ready=1 in the cycle following edge N+WAIT_CYCLES+1.
  - WAIT_CYCLES=0: ready follows edge N+1.
  - Default: ready follows edge N+3.
- Back-to-back transactions need at least one valid=0 sample between them.
- rdata is unchanged by writes and by the ready pulse of a write.
- Simultaneous events: a write to word X followed by a read of X returns the new data. Each transaction is serialised, so there is no read/write collision.
- Reset mid-transaction: an async rst_n low aborts everything. The FSM returns to IDLE, ready drops immediately, and a pending write is discarded.
- Input changes on addr/wdata/wr_en after capture are ignored until the next IDLE capture.

Optional Feature:
- Macro: BUS_SUB_STATS_EN.
- Defined:
  - Adds outputs wr_count[15:0] and rd_count[15:0], both reset to 0.
  - Each counter increments in the ACCESS cycle of a write or read respectively. Out-of-range accesses are included.
  - Both counters saturate at 16'hFFFF with no wrap.
- Undefined: no counter ports and no counter logic. All other behaviour is identical.

Test Plan:
- Write 32'hAAAA_BBBB to 8'h10, then read 8'h10 (defaults) -> ready pulses one cycle, 3 edges after the valid sample; read rdata=32'hAAAA_BBBB, err=0.
- Write 8'h10=32'hAAAA_BBBB and 8'h50=32'hCCCC_DDDD, then read both -> rdata 32'hAAAA_BBBB, then 32'hCCCC_DDDD; exactly two ready pulses per pair, none extra while valid is held.
- Read 8'h90 (out of range, DEPTH=128); write 32'h1234_5678 to 8'h90 -> read returns 32'hDEAD_BEEF with err=1 for one cycle; the write leaves all 128 words unchanged, with err=1.
- WAIT_CYCLES=0: write and read 8'h00 -> ready in the cycle after edge N+1; manager holds valid 3 extra cycles -> FSM stays in DONE with no second ready.
- Drop rst_n during WAIT of a write of 32'hFFFF_0000 to 8'h20 -> ready=0 immediately; after release, read 8'h20 returns 32'h0000_0000.
- BUS_SUB_STATS_EN: 3 writes and 2 reads -> wr_count=3, rd_count=2; with counters preloaded near max -> wr_count holds at 16'hFFFF.

Source files
------------

// File: rtl/bus_subordinate_mem.sv
// Word-addressed bus subordinate: DEPTH x 32 memory with programmable wait states and one-shot ready.
// Define BUS_SUB_STATS_EN to add saturating write/read access counters.
module bus_subordinate_mem #(
  parameter logic [7:0]  BASE_ADDR   = 8'h00,
  parameter int          DEPTH       = 128,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic        wr_en,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err
`ifdef BUS_SUB_STATS_EN
 ,output logic [15:0] wr_count,
  output logic [15:0] rd_count
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;

  state_t             state;
  logic [3:0]         cnt;
  logic               cap_we;
  logic               cap_hit;
  logic [IDX_W-1:0]   cap_idx;
  logic [31:0]        cap_wdata;
  logic [31:0]        mem [DEPTH];

  // 9-bit offset so the range test cannot wrap past address 255
  logic [8:0] off;
  logic       in_range;
  assign off      = {1'b0, addr} - {1'b0, BASE_ADDR};
  assign in_range = (addr >= BASE_ADDR) && (off < 9'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ready     <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_hit   <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
`ifdef BUS_SUB_STATS_EN
      wr_count  <= '0;
      rd_count  <= '0;
`endif
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: if (valid) begin
          cap_we    <= wr_en;
          cap_hit   <= in_range;
          cap_idx   <= off[IDX_W-1:0];
          cap_wdata <= wdata;
          if (WAIT_CYCLES > 0) begin
            cnt   <= 4'(WAIT_CYCLES - 1);
            state <= WAIT;
          end else begin
            state <= ACCESS;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= ACCESS;
          else             cnt   <= cnt - 4'd1;
        end
        ACCESS: begin
          ready <= 1'b1;
          err   <= !cap_hit;
          state <= DONE;
          if (cap_we) begin
            if (cap_hit) mem[cap_idx] <= cap_wdata;
`ifdef BUS_SUB_STATS_EN
            if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
`endif
          end else begin
            rdata <= cap_hit ? mem[cap_idx] : ERR_RDATA;
`ifdef BUS_SUB_STATS_EN
            if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
`endif
          end
        end
        // Held valid parks here so one request is never serviced twice
        DONE: if (!valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_subordinate_mem.sv
// Directed bench: default subordinate (2 wait states) plus a zero-wait instance on a shared clock/reset.
module tb_bus_subordinate_mem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v = 1'b0, we = 1'b0;
  logic [7:0]  a = '0;
  logic [31:0] d = '0;
  logic        ready, err;
  logic [31:0] rdata;
  logic        v0 = 1'b0, we0 = 1'b0;
  logic [7:0]  a0 = '0;
  logic [31:0] d0 = '0;
  logic        ready0, err0;
  logic [31:0] rdata0;
`ifdef BUS_SUB_STATS_EN
  logic [15:0] wr_count, rd_count, wr_count0, rd_count0;
`endif

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  bus_subordinate_mem dut (
    .clk(clk), .rst_n(rst_n), .valid(v), .wr_en(we), .addr(a), .wdata(d),
    .ready(ready), .rdata(rdata), .err(err)
`ifdef BUS_SUB_STATS_EN
   ,.wr_count(wr_count), .rd_count(rd_count)
`endif
  );

  bus_subordinate_mem #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .valid(v0), .wr_en(we0), .addr(a0), .wdata(d0),
    .ready(ready0), .rdata(rdata0), .err(err0)
`ifdef BUS_SUB_STATS_EN
   ,.wr_count(wr_count0), .rd_count(rd_count0)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One transaction on instance s (0 = default, 1 = zero-wait), starting at a negedge.
  // Inputs are scrambled after capture; valid is held 'hold' extra cycles after ready.
  task automatic txn(input bit s, input bit w, input logic [7:0] ad, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input bit exp_err, input int hold);
    int   c;
    logic rdy;
    int   lat;
    lat = s ? 1 : 3;
    if (s) begin v0 = 1'b1; we0 = w; a0 = ad; d0 = wd; end
    else   begin v  = 1'b1; we  = w; a  = ad; d  = wd; end
    c = 0; rdy = 1'b0;
    while (!rdy && c < 20) begin
      @(negedge clk);
      rdy = s ? ready0 : ready;
      if (!rdy) begin
        if (c == 0) begin
          if (s) begin we0 = ~w; a0 = ~ad; d0 = ~wd; end
          else   begin we  = ~w; a  = ~ad; d  = ~wd; end
        end
        c++;
      end
    end
    chk($sformatf("ready_seen s%0d a%h", s, ad), {31'd0, rdy}, 32'd1);
    chk($sformatf("latency s%0d a%h", s, ad), c, lat);
    chk($sformatf("rdata s%0d a%h", s, ad), s ? rdata0 : rdata, exp_rd);
    chk($sformatf("err s%0d a%h", s, ad), {31'd0, s ? err0 : err}, {31'd0, exp_err});
    @(negedge clk);
    chk($sformatf("ready_pulse s%0d a%h", s, ad), {31'd0, s ? ready0 : ready}, 32'd0);
    chk($sformatf("err_pulse s%0d a%h", s, ad), {31'd0, s ? err0 : err}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk($sformatf("held_no_ready s%0d a%h", s, ad), {31'd0, s ? ready0 : ready}, 32'd0);
    end
    if (s) v0 = 1'b0; else v = 1'b0;
    @(negedge clk);
    chk($sformatf("idle_no_ready s%0d a%h", s, ad), {31'd0, s ? ready0 : ready}, 32'd0);
    chk($sformatf("rdata_hold s%0d a%h", s, ad), s ? rdata0 : rdata, exp_rd);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic write/read, second word, held valid
    txn(0, 1, 8'h10, 32'hAAAA_BBBB, 32'h0000_0000, 0, 0);
    txn(0, 0, 8'h10, 32'h0,         32'hAAAA_BBBB, 0, 0);
    txn(0, 1, 8'h50, 32'hCCCC_DDDD, 32'hAAAA_BBBB, 0, 2);
    txn(0, 0, 8'h10, 32'h0,         32'hAAAA_BBBB, 0, 3);
    txn(0, 0, 8'h50, 32'h0,         32'hCCCC_DDDD, 0, 0);

    // Out of range and boundaries (BASE 0, DEPTH 128)
    txn(0, 0, 8'h90, 32'h0,         32'hDEAD_BEEF, 1, 0);
    txn(0, 1, 8'h90, 32'h1234_5678, 32'hDEAD_BEEF, 1, 0);
    txn(0, 0, 8'h10, 32'h0,         32'hAAAA_BBBB, 0, 0);
    txn(0, 0, 8'h50, 32'h0,         32'hCCCC_DDDD, 0, 0);
    txn(0, 0, 8'h7F, 32'h0,         32'h0000_0000, 0, 0);
    txn(0, 0, 8'h80, 32'h0,         32'hDEAD_BEEF, 1, 0);
`ifdef BUS_SUB_STATS_EN
    chk("wr_count", {16'd0, wr_count}, 32'd3);
    chk("rd_count", {16'd0, rd_count}, 32'd8);
`endif

    // Zero wait states, valid held 3 extra cycles
    txn(1, 1, 8'h00, 32'h1111_2222, 32'h0000_0000, 0, 0);
    txn(1, 0, 8'h00, 32'h0,         32'h1111_2222, 0, 3);

    // Reset while a write waits: write discarded, outputs clear at once
    v = 1'b1; we = 1'b1; a = 8'h20; d = 32'hFFFF_0000;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, ready}, 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    chk("midrst_rdata0", rdata0, 32'd0);
    v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    txn(0, 0, 8'h20, 32'h0, 32'h0000_0000, 0, 0);

    // Reset during the ready pulse drops ready asynchronously
    v0 = 1'b1; we0 = 1'b0; a0 = 8'h00; d0 = 32'h0;
    repeat (2) @(negedge clk);
    chk("pulse_before_rst", {31'd0, ready0}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("pulse_after_rst", {31'd0, ready0}, 32'd0);
    v0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    txn(1, 0, 8'h00, 32'h0, 32'h0000_0000, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
